// File: rtl/tt_pkg.sv
// Shared constants for the truth-table sweeper: FSM encoding, default
// expected table and width helpers.
package tt_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // s = ~a & b, with a on the MSB of the input vector
  localparam logic [3:0] F0105_EXPECTED = 4'b0010;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Bits needed to hold SETTLE-1; never narrower than one bit
  function automatic int cnt_width(input int settle);
    return (settle < 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module tt_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a small combinational DUT, captures its truth
// table and scores it. Define TT_SWEEP_ABORT_ON_MISMATCH_EN to stop at the
// first mismatch and expose the failing index on fail_idx.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int                             N_IN     = 2,
  parameter int                             SETTLE   = 1,
  parameter logic [tt_width(N_IN)-1:0]      EXPECTED = F0105_EXPECTED
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [tt_width(N_IN)-1:0] table_out,
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
  output logic [N_IN-1:0]           fail_idx,
`endif
  output logic [N_IN:0]             mismatch_cnt
);

  localparam int TW = tt_width(N_IN);
  localparam int MW = N_IN + 1;
  localparam int CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic [MW-1:0]   mis_q, mis_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] fidx_q, fidx_d;
  logic            tmr_load, tmr_dec, tmr_exp;
  logic            miss, last, stop;

  tt_settle_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .val_i     (LOAD_VAL),
    .dec_i     (tmr_dec),
    .expired_o (tmr_exp)
  );

  assign miss = (dut_out != EXPECTED[idx_q]);
  assign last = (idx_q == '1);
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
  assign stop = last | miss;
`else
  assign stop = last;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tbl_d    = tbl_q;
    mis_d    = mis_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fidx_d   = fidx_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = WAIT;
          idx_d    = '0;
          tbl_d    = '0;
          mis_d    = '0;
          fidx_d   = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      WAIT: begin
        if (tmr_exp) state_d = SAMPLE;
        else         tmr_dec = 1'b1;
      end
      SAMPLE: begin
        tbl_d[idx_q] = dut_out;
        mis_d        = mis_q + MW'(miss);
        if (miss) fidx_d = idx_q;
        // pass must reflect the sample taken on this very edge
        if (stop) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mis_d == '0);
        end else begin
          state_d  = WAIT;
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tbl_q   <= '0;
      mis_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
    end
  end

  assign dut_in       = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign table_out    = tbl_q;
  assign mismatch_cnt = mis_q;
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
  assign fail_idx     = fidx_q;
`else
  // fail index is only observable in the abort build
  logic unused_fidx;
  assign unused_fidx = ^fidx_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: the DUT under sweep is a
// programmable 2-input lookup table; expectations come from a sweep model.
module tb_truth_table_sweeper;

  localparam int         N_IN   = 2;
  localparam int         SETTLE = 1;
  localparam logic [3:0] EXP    = 4'b0010;   // s = ~a & b
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [3:0] table_out;
  logic [2:0] mismatch_cnt;
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
  logic [1:0] fail_idx;
`endif
  logic [3:0] fn_q = 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] trace[$];

  always #5 clk = ~clk;
  assign dut_out = fn_q[dut_in];

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(EXP)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .table_out    (table_out),
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
    .fail_idx     (fail_idx),
`endif
    .mismatch_cnt (mismatch_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: visit vectors in order, stop early in abort mode.
  function automatic void ref_sweep(input logic [3:0] fn, output logic [3:0] tbl,
                                    output int mis, output int visits, output int fidx);
    tbl = '0; mis = 0; visits = 0; fidx = 0;
    for (int v = 0; v < 4; v++) begin
      if (ABORT && mis > 0) break;
      visits++;
      tbl[v] = fn[v];
      if (fn[v] != EXP[v]) begin
        mis++;
        fidx = v;
      end
    end
  endfunction

  // Each vector is held SETTLE+1 edges (WAIT then SAMPLE) with busy high.
  function automatic int trace_errs(input int visits);
    int errs = 0;
    if (trace.size() != visits * (SETTLE + 1)) errs++;
    foreach (trace[k])
      if (trace[k] !== {1'b1, 2'(k / (SETTLE + 1))}) errs++;
    return errs;
  endfunction

  // Pulse start, then count edges until done (bounded), recording {busy,dut_in}.
  task automatic do_sweep(input logic [3:0] fn, input int restart_at, output int edges);
    fn_q  = fn;
    start = 1'b1;
    tick;
    start = 1'b0;
    edges = 0;
    trace.delete();
    while (!done && edges < 64) begin
      trace.push_back({busy, dut_in});
      start = (edges == restart_at);
      tick;
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    n_checks++;
    if ({busy, done, pass} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, pass});
    end
    n_checks++;
    if ({table_out, mismatch_cnt, dut_in} !== 9'd0) begin
      n_fail++; $display("FAIL reset_data table=%b mis=%0d dut_in=%b want all 0",
                         table_out, mismatch_cnt, dut_in);
    end
  endtask

  task automatic test_correct;
    int edges;
    do_sweep(4'b0010, -1, edges);
    n_checks++;
    if (edges != 8) begin
      n_fail++; $display("FAIL correct_latency got %0d edges want 8", edges);
    end
    n_checks++;
    if (trace_errs(4) != 0) begin
      n_fail++; $display("FAIL correct_dut_in_seq errors=%0d want 0", trace_errs(4));
    end
    n_checks++;
    if ({table_out, mismatch_cnt, pass, busy} !== {4'b0010, 3'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL correct_result table=%b mis=%0d pass=%b busy=%b want 0010 0 1 0",
                         table_out, mismatch_cnt, pass, busy);
    end
    // outputs hold in DONE while start stays low
    repeat (5) tick;
    n_checks++;
    if ({done, pass, table_out, mismatch_cnt} !== {1'b1, 1'b1, 4'b0010, 3'd0}) begin
      n_fail++; $display("FAIL done_hold done=%b pass=%b table=%b mis=%0d", done, pass,
                         table_out, mismatch_cnt);
    end
  endtask

  task automatic test_faulty_xor;
    int edges;
    do_sweep(4'b0110, -1, edges);
    n_checks++;
    if (edges != (ABORT ? 6 : 8)) begin
      n_fail++; $display("FAIL xor_latency got %0d want %0d", edges, ABORT ? 6 : 8);
    end
    n_checks++;
    if ({table_out, mismatch_cnt, pass, done} !== {4'b0110, 3'd1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL xor_result table=%b mis=%0d pass=%b done=%b want 0110 1 0 1",
                         table_out, mismatch_cnt, pass, done);
    end
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
    n_checks++;
    if (fail_idx !== 2'b10) begin
      n_fail++; $display("FAIL xor_fail_idx got %b want 10", fail_idx);
    end
`endif
  endtask

  task automatic test_random;
    int edges, mis, visits, fidx;
    logic [3:0] fn, tbl;
    for (int r = 0; r < 8; r++) begin
      fn = 4'($urandom_range(0, 15));
      ref_sweep(fn, tbl, mis, visits, fidx);
      do_sweep(fn, -1, edges);
      n_checks++;
      if (edges != visits * (SETTLE + 1) || trace_errs(visits) != 0) begin
        n_fail++; $display("FAIL rand_timing fn=%b edges=%0d want %0d trace_errs=%0d",
                           fn, edges, visits * (SETTLE + 1), trace_errs(visits));
      end
      n_checks++;
      if ({table_out, mismatch_cnt, pass} !== {tbl, 3'(mis), 1'(mis == 0)}) begin
        n_fail++; $display("FAIL rand_result fn=%b table=%b mis=%0d pass=%b want %b %0d %b",
                           fn, table_out, mismatch_cnt, pass, tbl, mis, mis == 0);
      end
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
      n_checks++;
      if (fail_idx !== 2'(fidx)) begin
        n_fail++; $display("FAIL rand_fail_idx fn=%b got %0d want %0d", fn, fail_idx, fidx);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    int edges, mis, visits, fidx;
    logic [3:0] tbl;
    // start re-pulsed while dut_in==1 must be ignored
    do_sweep(4'b0010, 2, edges);
    n_checks++;
    if (edges != 8 || table_out !== 4'b0010 || pass !== 1'b1) begin
      n_fail++; $display("FAIL busy_restart edges=%0d table=%b pass=%b want 8 0010 1",
                         edges, table_out, pass);
    end
    // restart from DONE clears the table on the start edge
    fn_q  = 4'b1101;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if ({table_out, mismatch_cnt, busy, done, pass} !== {4'b0000, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL done_restart_clear table=%b mis=%0d busy=%b done=%b pass=%b",
                         table_out, mismatch_cnt, busy, done, pass);
    end
    edges = 0;
    while (!done && edges < 64) begin tick; edges++; end
    ref_sweep(4'b1101, tbl, mis, visits, fidx);
    n_checks++;
    if (edges != visits * (SETTLE + 1) || table_out !== tbl || mismatch_cnt !== 3'(mis)) begin
      n_fail++; $display("FAIL done_restart_sweep edges=%0d table=%b mis=%0d want %0d %b %0d",
                         edges, table_out, mismatch_cnt, visits * (SETTLE + 1), tbl, mis);
    end
  endtask

  task automatic test_reset_mid;
    int edges;
    fn_q  = 4'b0010;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;    // now in SAMPLE for vector 2
    n_checks++;
    if (dut_in !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_position dut_in=%0d busy=%b want 2 1", dut_in, busy);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_checks++;
    if ({busy, done, pass, table_out, mismatch_cnt, dut_in} !== 12'd0) begin
      n_fail++; $display("FAIL mid_reset busy=%b done=%b pass=%b table=%b mis=%0d dut_in=%0d",
                         busy, done, pass, table_out, mismatch_cnt, dut_in);
    end
    do_sweep(4'b0010, -1, edges);
    n_checks++;
    if (edges != 8 || trace_errs(4) != 0 || table_out !== 4'b0010 || pass !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_sweep edges=%0d table=%b pass=%b", edges,
                         table_out, pass);
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_faulty_xor;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
